// File: rtl/drop_token_ctrl_pkg.sv
// Shared Connect Four constants, state encoding and board geometry helpers.
// Used by the token controller and by other keyboard-driven board stages.
package c4_pkg;

    localparam int NUM_COLS  = 7;
    localparam int NUM_ROWS  = 6;
    localparam int BOARD_X0  = 128;
    localparam int BOARD_Y0  = 112;
    localparam int CELL_W    = 56;
    localparam int HOVER_Y   = 40;
    localparam int FALL_STEP = 8;

    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_DROP  = 8'h2C;

    typedef enum logic [1:0] {HOVER, FALL, LAND, DONE} state_t;

    typedef logic [2:0] col_t;
    typedef logic [2:0] row_t;
    typedef logic [9:0] pix_t;

    function automatic pix_t col_x(col_t c);
        return pix_t'(BOARD_X0) + pix_t'(c) * pix_t'(CELL_W);
    endfunction

    function automatic pix_t row_y(row_t r);
        return pix_t'(BOARD_Y0) + pix_t'(r) * pix_t'(CELL_W);
    endfunction

endpackage

// File: rtl/drop_token_ctrl_key_edge.sv
// Keycode edge detector: one-frame left/right/drop pulses on a new, non-zero keycode.
// A held key produces a single pulse.
module key_edge
    import c4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keycode,
    output logic       left,
    output logic       right,
    output logic       drop
);

    logic [7:0] prev_keycode;
    logic       press;

    always_ff @(posedge clk) begin
        if (rst) prev_keycode <= '0;
        else     prev_keycode <= keycode;
    end

    assign press = (keycode != prev_keycode) && (keycode != 8'd0);
    assign left  = press && (keycode == KEY_LEFT);
    assign right = press && (keycode == KEY_RIGHT);
    assign drop  = press && (keycode == KEY_DROP);

endmodule

// File: rtl/drop_token_ctrl.sv
// Per-frame falling-token controller: column select, drop animation, column
// fill tracking and a one-frame placement event for the board memory.
module drop_token_ctrl
    import c4_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic [9:0] TokenX,
    output logic [9:0] TokenY,
    output logic       TokenPlayer,
    output logic       TokenActive,
    output logic       PlaceValid,
    output logic [2:0] PlaceCol,
    output logic [2:0] PlaceRow,
    output logic       PlacePlayer,
    output logic       BoardFull
);

    state_t                    state, state_n;
    col_t                      col, col_n;
    pix_t                      tok_y, tok_y_n, y_step;
    logic                      player, player_n;
    row_t                      target_row, target_row_n;
    pix_t                      target_y, target_y_n;
    logic [NUM_COLS-1:0][2:0]  heights, heights_n;
    logic                      all_full;
    logic                      k_left, k_right, k_drop;

    key_edge u_key_edge (
        .clk     (frame_clk),
        .rst     (Reset),
        .keycode (keycode),
        .left    (k_left),
        .right   (k_right),
        .drop    (k_drop)
    );

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state      <= HOVER;
            col        <= col_t'(3);
            tok_y      <= pix_t'(HOVER_Y);
            player     <= 1'b0;
            target_row <= '0;
            target_y   <= '0;
            heights    <= '0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            tok_y      <= tok_y_n;
            player     <= player_n;
            target_row <= target_row_n;
            target_y   <= target_y_n;
            heights    <= heights_n;
        end
    end

    always_comb begin
        state_n      = state;
        col_n        = col;
        tok_y_n      = tok_y;
        player_n     = player;
        target_row_n = target_row;
        target_y_n   = target_y;
        heights_n    = heights;
        y_step       = tok_y + pix_t'(FALL_STEP);
        case (state)
            HOVER: begin
                if (k_left && col != '0)
                    col_n = col - col_t'(1);
                else if (k_right && col != col_t'(NUM_COLS-1))
                    col_n = col + col_t'(1);
                else if (k_drop && heights[col] < row_t'(NUM_ROWS)) begin
                    target_row_n = row_t'(NUM_ROWS-1) - heights[col];
                    target_y_n   = row_y(target_row_n);
                    state_n      = FALL;
                end
            end
            // Leave FALL on the frame that lands on target_y, so the token
            // spends (target_y-HOVER_Y)/FALL_STEP frames in FALL and shows
            // target_y during the LAND frame.
            FALL: begin
                if (y_step >= target_y) begin
                    tok_y_n = target_y;
                    state_n = LAND;
                end else begin
                    tok_y_n = y_step;
                end
            end
            LAND: begin
                heights_n[col] = heights[col] + 3'd1;
                player_n       = ~player;
                tok_y_n        = pix_t'(HOVER_Y);
                state_n        = HOVER;
            end
            default: ;
        endcase
        // Checked against the post-increment heights so the last LAND goes to DONE.
        all_full = 1'b1;
        for (int c = 0; c < NUM_COLS; c++)
            if (heights_n[c] != row_t'(NUM_ROWS)) all_full = 1'b0;
        if (state == LAND && all_full) state_n = DONE;
    end

    assign TokenX      = col_x(col);
    assign TokenY      = tok_y;
    assign TokenPlayer = player;
    assign TokenActive = (state != DONE);
    assign BoardFull   = (state == DONE);
    assign PlaceValid  = (state == LAND);
    assign PlaceCol    = PlaceValid ? col        : 3'd0;
    assign PlaceRow    = PlaceValid ? target_row : 3'd0;
    assign PlacePlayer = PlaceValid ? player     : 1'b0;

endmodule
